// File: rtl/mipi_csi_tx_packet_encoder_8b2lane_if.sv
// ----------------------------------------------------------------------------
// mipi_csi_tx_packet_encoder_8b2lane_if
//   Request / payload / lane-output bundle of the two-lane CSI-2 packet encoder.
//   master : packet source (drives the request fields and payload bytes)
//   slave  : the encoder (drives the lane bytes and status pulses)
//
//   packet_start_i     request to send one packet (sampled in IDLE only)
//   virtual_channel_i  VC field, captured with the request
//   data_type_i        DT field; DT < 0x10 is a short packet
//   word_count_i       long-packet byte count or short-packet data field
//   data_i             payload bytes, [7:0] earlier byte (lane 0)
//   data_ready_o       payload request; data_i consumed on each edge it is high
//   data_o             lane bytes, [7:0] lane 0, [15:8] lane 1
//   output_valid_o     data_o carries HS bytes
//   busy_o             packet in progress
//   done_o             pulse with the final byte cycle
//   error_o            pulse when a request is rejected
// ----------------------------------------------------------------------------
interface mipi_csi_tx_packet_encoder_8b2lane_if;
    logic        packet_start_i;
    logic [1:0]  virtual_channel_i;
    logic [5:0]  data_type_i;
    logic [15:0] word_count_i;
    logic [15:0] data_i;
    logic        data_ready_o;
    logic [15:0] data_o;
    logic        output_valid_o;
    logic        busy_o;
    logic        done_o;
    logic        error_o;

    modport master (
        output packet_start_i, virtual_channel_i, data_type_i, word_count_i, data_i,
        input  data_ready_o, data_o, output_valid_o, busy_o, done_o, error_o
    );

    modport slave (
        input  packet_start_i, virtual_channel_i, data_type_i, word_count_i, data_i,
        output data_ready_o, data_o, output_valid_o, busy_o, done_o, error_o
    );
endinterface

// File: rtl/mipi_csi_tx_packet_encoder_8b2lane.sv
// ----------------------------------------------------------------------------
// mipi_csi_tx_packet_encoder_8b2lane
//   Builds a MIPI CSI-2 packet on two 8-bit lanes: sync word, packet header
//   (DI, WC, ECC), payload and CRC-16 footer for long packets. All lane
//   outputs are registered; data_ready_o is a combinational payload request
//   issued one cycle ahead of each payload slot.
//
//   clk_i      byte clock for both lanes
//   reset_n_i  asynchronous active-low reset
//   bus        slave side of mipi_csi_tx_packet_encoder_8b2lane_if
// ----------------------------------------------------------------------------
module mipi_csi_tx_packet_encoder_8b2lane (
    input  logic                                     clk_i,
    input  logic                                     reset_n_i,
    mipi_csi_tx_packet_encoder_8b2lane_if.slave      bus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_HDR0,
        ST_HDR1,
        ST_PAYLOAD,
        ST_FOOTER
    } state_t;

    state_t      state_q;
    logic [7:0]  di_q;
    logic [15:0] wc_q;
    logic        long_q;
    logic [14:0] cnt_q;     // payload cycles still to follow the current one
    logic [15:0] crc_q;
    logic [15:0] data_q;
    logic        valid_q;
    logic        busy_q;
    logic        done_q;
    logic        error_q;

    logic [5:0]  ecc_d;
    logic [15:0] crc_d;
    logic        req_long;
    logic        data_ready;

    // CSI-2 header ECC: 6-bit Hamming over {WC, DI}.
    function automatic logic [5:0] ecc6(input logic [23:0] d);
        logic [5:0] p;
        p[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
        p[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
        p[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
        p[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
        p[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
        p[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
        return p;
    endfunction

    // Reflected CRC-16 (0x8408), one byte, LSB first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        logic        fb;
        r = c;
        for (int unsigned i = 0; i < 8; i++) begin
            fb = r[0] ^ b[i];
            r  = {1'b0, r[15:1]};
            if (fb) begin
                r = r ^ 16'h8408;
            end
        end
        return r;
    endfunction

    always_comb begin
        ecc_d      = ecc6({wc_q, di_q});
        crc_d      = crc16_byte(crc16_byte(crc_q, bus.data_i[7:0]), bus.data_i[15:8]);
        req_long   = (bus.data_type_i >= 6'h10);
        // Request a word whenever the next registered slot is a payload slot.
        data_ready = ((state_q == ST_HDR1) && long_q && (wc_q[15:1] != '0)) ||
                     ((state_q == ST_PAYLOAD) && (cnt_q != '0));
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= ST_IDLE;
            di_q    <= '0;
            wc_q    <= '0;
            long_q  <= 1'b0;
            cnt_q   <= '0;
            crc_q   <= '1;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.packet_start_i) begin
                        if (req_long && bus.word_count_i[0]) begin
                            error_q <= 1'b1;
                        end else begin
                            di_q    <= {bus.virtual_channel_i, bus.data_type_i};
                            wc_q    <= bus.word_count_i;
                            long_q  <= req_long;
                            crc_q   <= '1;
                            data_q  <= 16'hB8B8;
                            valid_q <= 1'b1;
                            busy_q  <= 1'b1;
                            state_q <= ST_SYNC;
                        end
                    end
                end
                ST_SYNC: begin
                    data_q  <= {wc_q[7:0], di_q};
                    state_q <= ST_HDR0;
                end
                ST_HDR0: begin
                    data_q  <= {2'b00, ecc_d, wc_q[15:8]};
                    done_q  <= !long_q;
                    state_q <= ST_HDR1;
                end
                ST_HDR1: begin
                    if (!long_q) begin
                        data_q  <= '0;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (data_ready) begin
                        data_q  <= bus.data_i;
                        crc_q   <= crc_d;
                        cnt_q   <= wc_q[15:1] - 15'd1;
                        state_q <= ST_PAYLOAD;
                    end else begin
                        // Empty long packet: footer carries the untouched seed.
                        data_q  <= crc_q;
                        done_q  <= 1'b1;
                        state_q <= ST_FOOTER;
                    end
                end
                ST_PAYLOAD: begin
                    if (cnt_q != '0) begin
                        data_q <= bus.data_i;
                        crc_q  <= crc_d;
                        cnt_q  <= cnt_q - 15'd1;
                    end else begin
                        data_q  <= crc_q;
                        done_q  <= 1'b1;
                        state_q <= ST_FOOTER;
                    end
                end
                ST_FOOTER: begin
                    data_q  <= '0;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    data_q  <= '0;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.data_ready_o   = data_ready;
    assign bus.data_o         = data_q;
    assign bus.output_valid_o = valid_q;
    assign bus.busy_o         = busy_q;
    assign bus.done_o         = done_q;
    assign bus.error_o        = error_q;

endmodule

// File: doc/mipi_csi_tx_packet_encoder_8b2lane.md
MIPI_CSI_TX_PACKET_ENCODER_8B2LANE -- requirements
Module: mipi_csi_tx_packet_encoder_8b2lane

Interface
REQ-001 The block SHALL have one clock and one reset: the clock is rising-edge; reset is asynchronous and active-low.
REQ-002 Port clk_i  input  1  byte clock for both lanes.
REQ-003 Port reset_n_i  input  1  asynchronous active-low reset.
REQ-004 Port packet_start_i  input  1  request to send one packet; sampled only in IDLE.
REQ-005 Port virtual_channel_i  input  2  VC field, captured with the request.
REQ-006 Port data_type_i  input  6  DT field, captured with the request; DT < 0x10 is a short packet, otherwise a long packet.
REQ-007 Port word_count_i  input  16  payload byte count for a long packet, or the 16-bit data field for a short packet; captured with the request.
REQ-008 Port data_i  input  16  payload bytes; [7:0] is the earlier byte (lane 0), [15:8] the later byte (lane 1).
REQ-009 Port data_ready_o  output  1  payload request; data_i is consumed on every clock edge where this output is high; the source cannot stall.
REQ-010 Port data_o  output  16  lane bytes; [7:0] is lane 0, [15:8] is lane 1.
REQ-011 Port output_valid_o  output  1  data_o carries HS bytes.
REQ-012 Port busy_o  output  1  high from request acceptance until the final byte cycle completes.
REQ-013 Port done_o  output  1  one-cycle pulse when the final byte cycle is on data_o.
REQ-014 Port error_o  output  1  one-cycle pulse when a request is rejected.

Function
REQ-015 Requests are accepted in IDLE only, when packet_start_i=1; VC, DT and WC are registered at acceptance; packet_start_i SHALL be ignored while busy_o=1.
REQ-016 A long-packet request with word_count_i[0]=1 SHALL be rejected: error_o pulses the next cycle, the block stays in IDLE, and nothing is transmitted.
REQ-017 States: IDLE, SYNC, HDR0, HDR1, PAYLOAD, FOOTER; all outputs are registered.
REQ-018 Byte sequence (data_o, lane0 = low byte):
  - SYNC: 0xB8B8.
  - HDR0: {WC[7:0], DI}, where DI = {VC, DT}.
  - HDR1: {ECC, WC[15:8]}.
  - PAYLOAD: data_i, for WC/2 cycles.
  - FOOTER: {CRC[15:8], CRC[7:0]}.
REQ-019 Latency: SYNC appears on data_o on the cycle after acceptance; output_valid_o=1 for every state except IDLE.
REQ-020 ECC SHALL be the CSI-2 6-bit Hamming code over the 24 bits {WC[15:0], DI[7:0]}, with ECC[7:6]=0.
REQ-021 Short packet: the sequence SHALL end after HDR1 (3 valid cycles); done_o is asserted with HDR1.
REQ-022 Long packet with WC=0: HDR1 SHALL go directly to FOOTER with CRC=0xFFFF.
REQ-023 data_ready_o SHALL be high one cycle before each PAYLOAD cycle, i.e. a combinational request during the HDR1 cycle and the PAYLOAD cycles except the last, so each byte is registered into its PAYLOAD slot; the total is exactly WC/2 assertions.
REQ-024 CRC SHALL be CSI-2 CRC-16:
  - polynomial x^16+x^12+x^5+1, reflected 0x8408;
  - seed 0xFFFF, processed LSB-first;
  - per cycle, byte [7:0] first and then [15:8];
  - computed over payload bytes only;
  - no final inversion.
REQ-025 The CRC accumulator SHALL re-seed on every acceptance.
REQ-026 After FOOTER, the block SHALL return to IDLE: output_valid_o=0 and busy_o=0 on the next cycle; a new request is accepted no earlier than that IDLE cycle (minimum one idle cycle between packets).
REQ-027 The payload counter SHALL be 15 bits wide (WC/2) and SHALL count down to zero without wrap; WC=0xFFFE is legal and produces 32767 payload cycles.
REQ-028 data_o SHALL be 0x0000 whenever output_valid_o=0.

Reset
REQ-029 On reset_n_i=0, the block SHALL immediately enter IDLE with data_o=0x0000 and output_valid_o, data_ready_o, busy_o, done_o and error_o all 0, including mid-packet; the packet is abandoned with no footer.
REQ-030 After reset release, the first request SHALL be accepted on the first rising edge where reset_n_i=1 and packet_start_i=1.

Verification
REQ-031 Short packet (VC=0, DT=0x00, WC=0x0000) -> B8B8, 0000, 0000 (ECC 0x00); done_o with the third word; 3 valid cycles.
REQ-032 Long packet (DT=0x2B, WC=24), payload FF 00 00 02 B9 DC F3 72 BB D4 B8 5A C8 75 C2 7C 81 F8 05 DF FF 00 00 01 -> 12 data_ready_o pulses, footer 0x00F0 (data_o=0x00F0).
REQ-033 Long packet (WC=24), payload FF 00 00 00 1E F0 1E C7 4F 82 78 C5 82 E0 8C 70 D2 3C 78 E9 FF 00 00 01 -> footer data_o=0xE569; output fed to mipi_csi_rx_packet_decoder_8b2lane recovers packet_length 24 and all payload bytes, with the ECC cross-checked.
REQ-034 WC=0 long packet -> B8B8, hdr0, hdr1, FFFF, then IDLE; WC=7 -> error_o pulse, output_valid_o stays 0.
REQ-035 reset_n_i low during PAYLOAD -> all outputs 0 asynchronously; a subsequent request produces a correct packet with fresh CRC; packet_start_i pulses while busy are ignored.
